coin_acceptor: RTL and testbench

//   Coin-slot front end. Produces the coin[1:0] code stream consumed by the vending-machine FSM.

---
 rtl/coin_acceptor.sv | 184 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: sync + debounce two sensors, queue up to 2 coins, emit 1-cycle codes.
// Latency: raw rise before edge 0 -> code on o_coin after edge DEBOUNCE_CYCLES+3.
// Backpressure: i_inhibit stalls emission from IDLE and rejects new coins; a full queue also rejects.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int CNT_W           = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_nickel_sns,
    input  logic       i_dime_sns,
    input  logic       i_inhibit,
    output logic [1:0] o_coin,
    output logic       o_reject,
    output logic [1:0] o_pending,
    output logic [3:0] o_drop_cnt
);
    localparam int               GAP_W       = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       CODE_NICKEL = 2'b01;
    localparam logic [1:0]       CODE_DIME   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

    // Channel 0 = nickel, channel 1 = dime.
    logic [1:0]       w_raw;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_db;
    logic [1:0]       r_evt;
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0]       r_q [2];
    logic [1:0]       r_qcnt;
    logic             r_reject;
    logic [3:0]       r_drop;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [1:0]       r_coin;
    logic [1:0]       w_coin_nxt;
    logic             w_pop;
    logic             w_can_launch;

    logic             w_push_n;
    logic             w_push_d;
    logic             w_drop_n;
    logic             w_drop_d;
    logic [1:0]       w_ndrop;
    logic [4:0]       w_drop_sum;
    logic [1:0]       w_idx;
    logic [1:0]       w_q0_nxt;
    logic [1:0]       w_q1_nxt;

    assign w_raw = {i_dime_sns, i_nickel_sns};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_db  <= '0;
            r_evt <= '0;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                r_evt[i] <= 1'b0;
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    // Only a rising debounced level is a coin; the fall just re-arms.
                    r_cnt[i] <= '0;
                    r_db[i]  <= ~r_db[i];
                    r_evt[i] <= ~r_db[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot.
    assign w_push_n   = r_evt[0] && !i_inhibit && (r_qcnt != 2'd2);
    assign w_push_d   = r_evt[1] && !i_inhibit &&
                        (w_push_n ? (r_qcnt == 2'd0) : (r_qcnt != 2'd2));
    assign w_drop_n   = r_evt[0] && !w_push_n;
    assign w_drop_d   = r_evt[1] && !w_push_d;
    assign w_ndrop    = {1'b0, w_drop_n} + {1'b0, w_drop_d};
    assign w_drop_sum = {1'b0, r_drop} + {3'b000, w_ndrop};

    always_comb begin
        w_q0_nxt = w_pop ? r_q[1] : r_q[0];
        w_q1_nxt = r_q[1];
        w_idx    = r_qcnt - {1'b0, w_pop};
        if (w_push_n) begin
            if (w_idx == 2'd0) w_q0_nxt = CODE_NICKEL;
            else               w_q1_nxt = CODE_NICKEL;
            w_idx = w_idx + 2'd1;
        end
        if (w_push_d) begin
            if (w_idx == 2'd0) w_q0_nxt = CODE_DIME;
            else               w_q1_nxt = CODE_DIME;
            w_idx = w_idx + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q[0]   <= '0;
            r_q[1]   <= '0;
            r_qcnt   <= '0;
            r_reject <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_q[0]   <= w_q0_nxt;
            r_q[1]   <= w_q1_nxt;
            r_qcnt   <= w_idx;
            r_reject <= w_drop_n | w_drop_d;
            r_drop   <= (w_drop_sum > 5'd15) ? 4'd15 : w_drop_sum[3:0];
        end
    end

    assign w_can_launch = (r_qcnt != 2'd0) && !i_inhibit;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_coin_nxt  = r_coin;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_launch) begin
                    w_pop       = 1'b1;
                    w_coin_nxt  = r_q[0];
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_coin_nxt  = 2'b00;
                w_gap_nxt   = GAP_W'(GAP_CYCLES);
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_coin_nxt = 2'b00;
                // The last gap cycle doubles as IDLE so codes can follow every GAP_CYCLES+1 cycles.
                if (r_gap < GAP_W'(2)) begin
                    w_state_nxt = S_IDLE;
                    if (w_can_launch) begin
                        w_pop       = 1'b1;
                        w_coin_nxt  = r_q[0];
                        w_state_nxt = S_EMIT;
                    end
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_coin_nxt  = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_coin  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_coin  <= w_coin_nxt;
        end
    end

    assign o_coin     = r_coin;
    assign o_reject   = r_reject;
    assign o_pending  = r_qcnt;
    assign o_drop_cnt = r_drop;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected codes queued on stimulus, popped when o_coin fires.
module tb_coin_acceptor;
    logic       clk;
    logic       i_reset;
    logic       i_nickel_sns;
    logic       i_dime_sns;
    logic       i_inhibit;
    logic [1:0] o_coin;
    logic       o_reject;
    logic [1:0] o_pending;
    logic [3:0] o_drop_cnt;

    int         errors = 0;
    int         checks = 0;
    int         rej_pulses = 0;
    int         coins_seen = 0;
    int         max_pend = 0;
    int         base;
    logic [1:0] prev_coin = 2'b00;
    logic [1:0] exp_q [$];

    coin_acceptor dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_nickel_sns (i_nickel_sns),
        .i_dime_sns   (i_dime_sns),
        .i_inhibit    (i_inhibit),
        .o_coin       (o_coin),
        .o_reject     (o_reject),
        .o_pending    (o_pending),
        .o_drop_cnt   (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every non-idle code must match the oldest expected code and follow a 00 cycle.
    always @(negedge clk) begin
        if (!i_reset) begin
            prev_coin = 2'b00;
        end else begin
            if (o_reject) rej_pulses++;
            if (int'(o_pending) > max_pend) max_pend = int'(o_pending);
            if (o_coin !== 2'b00) begin
                coins_seen++;
                if (exp_q.size() == 0) chk("unexpected_coin", {30'd0, o_coin}, 32'd0);
                else                   chk("coin_order", {30'd0, o_coin}, {30'd0, exp_q.pop_front()});
                chk("coin_gap", {30'd0, prev_coin}, 32'd0);
            end
            prev_coin = o_coin;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_nickel_sns = 1'b0; i_dime_sns = 1'b0; i_inhibit = 1'b0;
        tick(3);
        chk("rst_coin", {30'd0, o_coin}, 32'd0);
        chk("rst_reject", {31'd0, o_reject}, 32'd0);
        chk("rst_pending", {30'd0, o_pending}, 32'd0);
        chk("rst_drop", {28'd0, o_drop_cnt}, 32'd0);
        i_reset = 1'b1;
        tick(2);

        // Single nickel held 10 cycles: code after edge 7, one cycle wide.
        i_nickel_sns = 1'b1; exp_q.push_back(2'b01);
        tick(7);
        chk("t1_pending_1", {30'd0, o_pending}, 32'd1);
        chk("t1_early", {30'd0, o_coin}, 32'd0);
        tick(1);
        chk("t1_latency", {30'd0, o_coin}, 32'd1);
        chk("t1_pending_0", {30'd0, o_pending}, 32'd0);
        tick(1);
        chk("t1_width", {30'd0, o_coin}, 32'd0);
        tick(1);
        i_nickel_sns = 1'b0;
        tick(12);
        chk("t1_no_reject", rej_pulses, 32'd0);
        chk("t1_coins", coins_seen, 32'd1);

        // Bouncing dime then a solid hold: exactly one dime.
        base = coins_seen;
        for (int i = 0; i < 4; i++) begin
            i_dime_sns = (i % 2 == 0);
            tick(1);
        end
        i_dime_sns = 1'b1; exp_q.push_back(2'b10);
        tick(10);
        i_dime_sns = 1'b0;
        tick(12);
        chk("t2_one_dime", coins_seen - base, 32'd1);
        chk("t2_sb_empty", exp_q.size(), 32'd0);

        // Simultaneous rise: nickel first, one idle cycle, then dime.
        max_pend = 0;
        i_nickel_sns = 1'b1; i_dime_sns = 1'b1;
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        tick(7);
        chk("t3_pending_2", {30'd0, o_pending}, 32'd2);
        tick(1);
        chk("t3_first", {30'd0, o_coin}, 32'd1);
        tick(1);
        chk("t3_gap", {30'd0, o_coin}, 32'd0);
        tick(1);
        chk("t3_second", {30'd0, o_coin}, 32'd2);
        i_nickel_sns = 1'b0; i_dime_sns = 1'b0;
        tick(12);
        chk("t3_peak", max_pend, 32'd2);
        chk("t3_no_reject", rej_pulses, 32'd0);

        // Three coins while inhibited: all rejected, nothing emitted.
        base = coins_seen; rej_pulses = 0;
        i_inhibit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) i_dime_sns = 1'b1; else i_nickel_sns = 1'b1;
            tick(8);
            i_nickel_sns = 1'b0; i_dime_sns = 1'b0;
            tick(8);
        end
        chk("t4_rejects", rej_pulses, 32'd3);
        chk("t4_drop3", {28'd0, o_drop_cnt}, 32'd3);
        i_inhibit = 1'b0;
        tick(4);
        chk("t4_no_coin", coins_seen - base, 32'd0);
        chk("t4_pending0", {30'd0, o_pending}, 32'd0);

        // Fill both slots, stall, then a third coin arrives exactly as inhibit drops: refused as full.
        i_nickel_sns = 1'b1; i_dime_sns = 1'b1;
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        tick(7);
        i_inhibit = 1'b1; i_nickel_sns = 1'b0; i_dime_sns = 1'b0;
        chk("t4_queued2", {30'd0, o_pending}, 32'd2);
        tick(9);
        i_nickel_sns = 1'b1;
        tick(6);
        chk("t4_stalled", {30'd0, o_coin}, 32'd0);
        chk("t4_still2", {30'd0, o_pending}, 32'd2);
        i_inhibit = 1'b0;
        tick(1);
        chk("t4_rel_first", {30'd0, o_coin}, 32'd1);
        chk("t4_full_reject", {31'd0, o_reject}, 32'd1);
        chk("t4_drop4", {28'd0, o_drop_cnt}, 32'd4);
        chk("t4_pending1", {30'd0, o_pending}, 32'd1);
        tick(1);
        chk("t4_rel_gap", {30'd0, o_coin}, 32'd0);
        chk("t4_reject_1cyc", {31'd0, o_reject}, 32'd0);
        tick(1);
        chk("t4_rel_second", {30'd0, o_coin}, 32'd2);
        i_nickel_sns = 1'b0;
        tick(12);
        chk("t4_sb_empty", exp_q.size(), 32'd0);

        // Reset during the EMIT cycle truncates the code at once and flushes everything.
        i_nickel_sns = 1'b1;
        tick(8);
        chk("t5_launched", {30'd0, o_coin}, 32'd1);
        #1 i_reset = 1'b0;
        #1;
        chk("t5_async_coin", {30'd0, o_coin}, 32'd0);
        chk("t5_pending", {30'd0, o_pending}, 32'd0);
        chk("t5_drop", {28'd0, o_drop_cnt}, 32'd0);
        tick(1);
        i_reset = 1'b1; exp_q.push_back(2'b01);
        tick(7);
        chk("t5_re_pending", {30'd0, o_pending}, 32'd1);
        tick(1);
        chk("t5_re_latency", {30'd0, o_coin}, 32'd1);
        i_nickel_sns = 1'b0;
        tick(12);

        // Saturation: one double rejection (+2, single pulse) then 18 singles.
        rej_pulses = 0;
        i_inhibit = 1'b1;
        i_nickel_sns = 1'b1; i_dime_sns = 1'b1;
        tick(8);
        i_nickel_sns = 1'b0; i_dime_sns = 1'b0;
        tick(8);
        chk("t6_double_drop", {28'd0, o_drop_cnt}, 32'd2);
        chk("t6_double_pulse", rej_pulses, 32'd1);
        for (int i = 0; i < 18; i++) begin
            if (i % 2 == 0) i_nickel_sns = 1'b1; else i_dime_sns = 1'b1;
            tick(8);
            i_nickel_sns = 1'b0; i_dime_sns = 1'b0;
            tick(8);
        end
        chk("t6_saturated", {28'd0, o_drop_cnt}, 32'd15);
        chk("t6_pulses", rej_pulses, 32'd19);
        i_inhibit = 1'b0;
        tick(4);
        chk("end_sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
